ppu_pixel_sink: RTL
===================

Name: ppu_pixel_sink

Overview:
- Receiving end of the PPU pixel stream: consumes 2-bit pixels qualified by a valid strobe and packs 16 pixels per 32-bit word.
- Tracks screen position and writes packed words to the LCD framebuffer through a valid/ready write port, with a small word buffer between them.
- Sits between the PPU pixel output and the framebuffer/video scan-out logic; resynchronises on the V-blank interrupt pulse.

Parameters:
H_PIXELS, 160, visible pixels per line (multiple of 16)
V_LINES, 144, visible lines per frame
FIFO_DEPTH, 4, packed-word buffer depth (power of 2, >=2)
ADDR_W, 11, framebuffer word-address width; must cover H_PIXELS*V_LINES/16 words

Ports:
clk  in  1  system clock
rstN  in  1  asynchronous active-low reset
px_in  in  2  pixel colour index from PPU
px_valid  in  1  px_in valid this cycle; no backpressure toward PPU
vblank_start  in  1  one-cycle pulse at V-blank entry (PPU V-blank IRQ)
clr_err  in  1  clears sticky error flags
bgp  in  8  palette register (used only with SINK_PALETTE_EN)
fb_wr_en  out  1  write request valid
fb_addr  out  ADDR_W  framebuffer word address
fb_wr_data  out  32  16 packed pixels
fb_wr_ready  in  1  framebuffer accepts write
cur_line  out  8  current line being filled (0..V_LINES-1)
frame_done  out  1  one-cycle pulse when last word of frame is pushed
overflow  out  1  sticky: word dropped because buffer full
frame_err  out  1  sticky: short frame or excess pixels

Behaviour:
- Reset (rstN low, async): all outputs 0; x, line, pixel count, word address, buffer pointers cleared; buffered words discarded. Reset mid-transfer drops fb_wr_en immediately.
- States: FILL (accepting pixels), DONE (frame complete, waiting for vblank_start). Reset -> FILL.
- FILL: each px_valid pixel goes into pack slot pix_cnt (0..15). Pixel n occupies bits [2n+1:2n]; leftmost pixel in LSBs. x increments; at x==H_PIXELS-1, x->0, cur_line++.
- When the 16th pixel is accepted, {word, word_addr} is pushed into the buffer at that same edge, pix_cnt->0 and word_addr++.
- Word address: starts at 0 each frame, increments once per pushed or dropped word; never wraps inside a frame.
- After the last word (word_addr = H_PIXELS*V_LINES/16-1) is pushed: frame_done pulses for 1 cycle on the next cycle; state -> DONE.
- DONE: px_valid pixels are ignored and set frame_err.
- vblank_start (either state): x, cur_line, pix_cnt and word_addr -> 0; state -> FILL.
  - In FILL with any pixel already received this frame: partial word discarded, frame_err set.
  - Buffered words are not discarded.
- vblank_start and px_valid in the same cycle: vblank wins; that pixel is discarded and is not counted toward frame_err.
- Buffer: first-word-fall-through. fb_wr_en = not empty; fb_addr/fb_wr_data are the head entry. Pop on fb_wr_en && fb_wr_ready.
- Latency: 16th pixel at edge N -> fb_wr_en high after edge N if buffer was empty.
- Buffer full at push time: the word is dropped, overflow set, word_addr still increments. Simultaneous pop and push when full: pop frees the slot, so the push succeeds with no overflow.
- fb_addr/fb_wr_data stay stable while fb_wr_en && !fb_wr_ready.
- Sticky flags: clr_err clears both. Clear and set in the same cycle: set wins.

Optional Feature:
SINK_PALETTE_EN
- Defined: stored pixel = bgp[2*px_in+1 : 2*px_in], using bgp sampled in the same cycle as px_valid.
- Undefined: raw px_in is stored and bgp is ignored; the port remains present.

Test Plan:
- Reset, fb_wr_ready=1, 16 valid pixels 0,1,2,3 repeating -> one write, fb_addr=0, fb_wr_data=0xE4E4E4E4, fb_wr_en high 1 cycle after the 16th pixel.
- Full frame of 23040 pixels, fb_wr_ready=1 -> 1440 writes, addresses 0..1439; frame_done pulses once after the final push; cur_line reached 143; no flags set.
- fb_wr_ready=0, FIFO_DEPTH=4, stream 80 pixels (5 words) -> 4 words held, overflow=1; after ready=1 the writes carry addresses 0,1,2,3; the next word written uses address 5.
- 100 pixels then vblank_start -> frame_err=1; next 16 pixels written to fb_addr=0; clr_err -> frame_err=0.
- vblank_start coincident with px_valid at frame start -> pixel not stored and frame_err stays 0; assert rstN low while fb_wr_en=1 -> fb_wr_en=0 immediately with no further writes.
- SINK_PALETTE_EN, bgp=0x1B, 16 pixels of 0 -> fb_wr_data=0xFFFFFFFF.

Source files
------------

// File: rtl/ppu_pixel_sink.sv
// PPU pixel sink: packs 2-bit pixels into 32-bit words and writes them to the framebuffer
// through a small first-word-fall-through buffer. Optional palette mapping: SINK_PALETTE_EN.
module ppu_pixel_sink #(
  parameter int unsigned H_PIXELS   = 160,
  parameter int unsigned V_LINES    = 144,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [1:0]        px_in,
  input  logic              px_valid,
  input  logic              vblank_start,
  input  logic              clr_err,
  input  logic [7:0]        bgp,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [31:0]       fb_wr_data,
  input  logic              fb_wr_ready,
  output logic [7:0]        cur_line,
  output logic              frame_done,
  output logic              overflow,
  output logic              frame_err
);

  localparam int unsigned Words = H_PIXELS * V_LINES / 16;
  localparam int unsigned XW    = $clog2(H_PIXELS);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);

  typedef enum logic {StFill, StDone} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [7:0]        line_q, line_d;
  logic [3:0]        pix_cnt_q, pix_cnt_d;
  logic [31:0]       pack_q, pack_d, pack_word;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic              err_set, ovf_set, push_req, push_ok, pop, empty, full, in_frame_px;
  logic [1:0]        px_val;

  logic [PW:0]          wr_ptr_q, rd_ptr_q;
  logic [ADDR_W+31:0]   mem_q [FIFO_DEPTH];

`ifdef SINK_PALETTE_EN
  assign px_val = bgp[{px_in, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign px_val     = px_in;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop   = !empty && fb_wr_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push_req && (!full || pop);

  // x and line are only both zero before the first pixel of a frame.
  assign in_frame_px = (x_q != '0) || (line_q != '0);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    line_d       = line_q;
    pix_cnt_d    = pix_cnt_q;
    pack_d       = pack_q;
    word_addr_d  = word_addr_q;
    frame_done_d = 1'b0;
    err_set      = 1'b0;
    push_req     = 1'b0;
    pack_word    = pack_q;
    pack_word[{pix_cnt_q, 1'b0} +: 2] = px_val;

    if (vblank_start) begin
      x_d         = '0;
      line_d      = '0;
      pix_cnt_d   = '0;
      word_addr_d = '0;
      state_d     = StFill;
      if (state_q == StFill && in_frame_px) err_set = 1'b1;
    end else if (px_valid) begin
      if (state_q == StDone) begin
        err_set = 1'b1;
      end else begin
        pack_d    = pack_word;
        pix_cnt_d = pix_cnt_q + 4'd1;
        if (x_q == XW'(H_PIXELS - 1)) begin
          x_d = '0;
          if (line_q != 8'(V_LINES - 1)) line_d = line_q + 8'd1;
        end else begin
          x_d = x_q + 1'b1;
        end
        if (pix_cnt_q == 4'd15) begin
          push_req    = 1'b1;
          word_addr_d = word_addr_q + 1'b1;
          if (word_addr_q == ADDR_W'(Words - 1)) begin
            frame_done_d = 1'b1;
            state_d      = StDone;
          end
        end
      end
    end

    ovf_set     = push_req && full && !pop;
    overflow_d  = ovf_set | (overflow_q & ~clr_err);
    frame_err_d = err_set | (frame_err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StFill;
      x_q          <= '0;
      line_q       <= '0;
      pix_cnt_q    <= '0;
      pack_q       <= '0;
      word_addr_q  <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      line_q       <= line_d;
      pix_cnt_q    <= pix_cnt_d;
      pack_q       <= pack_d;
      word_addr_q  <= word_addr_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= {word_addr_q, pack_word};
  end

  // Gate the head entry so outputs read zero while the buffer is empty.
  assign fb_wr_en                = !empty;
  assign {fb_addr, fb_wr_data}   = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign cur_line                = line_q;
  assign frame_done              = frame_done_q;
  assign overflow                = overflow_q;
  assign frame_err               = frame_err_q;

endmodule
